mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the multi-cycle CPU's data/instruction memory accesses.
- The CPU control sequencer acts as initiator. It raises a request with address, write-enable and write data, then waits for acknowledge.
- This block owns a word-organised RAM and answers each request after a programmable number of wait states.
- It uses a four-phase Req/Ack handshake, so the controller can stall in its memory states.

Parameters:
- DATA_WIDTH, 32, width of data words.
- ADDR_WIDTH, 10, byte-address width. Depth is 2^(ADDR_WIDTH-2) words.
- WAIT_CYCLES, 2, wait states inserted between request acceptance and Ack (0..15).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-low reset (Reset=0 sampled at a rising edge resets the block).
- Req  input  1  access request from CPU control; held high until Ack seen.
- We  input  1  1 = write, 0 = read; sampled with Req in IDLE.
- Addr  input  ADDR_WIDTH  byte address; Addr[1:0] must be 00.
- WData  input  DATA_WIDTH  write data; sampled with Req in IDLE.
- RData  output  DATA_WIDTH  read data; valid while Ack=1.
- Ack  output  1  access complete; held while Req stays high.
- Err  output  1  misaligned access flag; valid only while Ack=1.
- Busy  output  1  high in WAIT and RESP.

Behaviour:
- Reset:
  - State = IDLE; Ack=0, Err=0, Busy=0, RData=0; wait counter=0.
  - RAM contents are not reset.
  - Reset mid-transaction aborts it. A pending write is discarded.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - Req=1 at an edge latches Addr, We and WData into internal registers and loads counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
  - Inputs are ignored outside IDLE, except Req.
- WAIT:
  - Counter decrements each cycle. At counter==1 the next state is RESP.
  - If Req drops during WAIT, the access is aborted: return to IDLE, no write, no Ack.
- Entering RESP (single edge):
  - Aligned read: RData <= RAM[latched Addr[ADDR_WIDTH-1:2]], Err<=0.
  - Aligned write: RAM word written with latched WData exactly once; RData <= latched WData (write-through echo); Err<=0.
  - Misaligned (latched Addr[1:0]!=0): no RAM write, RData<=0, Err<=1.
  - Ack<=1.
- RESP:
  - Ack, Err and RData are held stable while Req=1.
  - When Req=0 is sampled: Ack<=0, Err<=0, next state IDLE. RData keeps its last value.
  - A new request cannot be accepted until the edge after Ack falls. That is the four-phase minimum gap of one IDLE cycle.
- Latency: Req sampled at edge 0 gives Ack high after edge WAIT_CYCLES+1. With WAIT_CYCLES=0, Ack is high after edge 1.
- Busy=1 exactly when the state is WAIT or RESP.
- Address wrap: no out-of-range case exists. The full Addr width maps onto RAM depth.
- Simultaneous events:
  - Reset low overrides all.
  - Req falling on the same edge the counter expires takes the abort path (no write).

Decomposition:
- Shared package mem_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2;
  - the default WAIT_CYCLES;
  - the word-offset width constant (2).
- Sub-module mem_array: single-port RAM, DATA_WIDTH x 2^(ADDR_WIDTH-2), synchronous write and combinational read.
  - Instantiated once.
  - The FSM and handshake logic live in mem_responder.

Test Plan:
- Reset (Reset=0 two edges, then 1) -> Ack=0, Err=0, Busy=0, RData=0, state IDLE.
- Write then read, WAIT_CYCLES=2:
  - Req=1, We=1, Addr=0x010, WData=0xDEADBEEF -> Ack rises after edge 3, RData=0xDEADBEEF.
  - Drop Req -> Ack low next edge.
  - Read of Addr=0x010 -> Ack after edge 3, RData=0xDEADBEEF, Err=0.
- Misaligned: Req=1, We=1, Addr=0x013, WData=0x12345678 -> Ack with Err=1, RData=0. Subsequent read of 0x010 still returns 0xDEADBEEF.
- Abort: write request to Addr=0x020 with 0xA5A5A5A5, Req dropped after 1 cycle in WAIT -> no Ack, back to IDLE, read of 0x020 returns its prior value.
- Held Ack / gap:
  - Req held high 5 cycles after Ack -> Ack, RData and Err stable throughout.
  - Req low 1 cycle, then a new read -> accepted on the next edge with correct latency.
- Reset mid-op, WAIT_CYCLES=0: write 0x0000FFFF to Addr=0x004, Reset=0 on edge 1 -> no Ack, Busy=0, RAM[1] unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: FSM encoding, default wait
// states and the byte-offset width of a word address.
package mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int DEF_WAIT_CYCLES = 2;
    localparam int WORD_OFS_W      = 2;
endpackage

// File: rtl/mem_array.sv
// Word-organised single-port RAM: synchronous write, combinational read.
// Contents are deliberately not reset.
module mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [IDX_WIDTH-1:0]  idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2**IDX_WIDTH];

    // Word write on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a four-phase Req/Ack request from the CPU
// sequencer, inserts WAIT_CYCLES wait states, performs the RAM access on the
// first edge spent in RESP, then holds Ack until Req drops.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req,
    input  logic                  We,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] WData,
    output logic [DATA_WIDTH-1:0] RData,
    output logic                  Ack,
    output logic                  Err,
    output logic                  Busy
);
    localparam int             IDX_W     = ADDR_WIDTH - WORD_OFS_W;
    localparam logic [3:0]     WAIT_INIT = 4'(WAIT_CYCLES);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;

    logic                    misaligned;
    logic                    ram_we;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign misaligned = (addr_q[WORD_OFS_W-1:0] != '0);

    // The access edge is the first RESP edge with Req still high; a low
    // Reset on that edge cancels the write so an aborted access leaves RAM intact.
    assign ram_we = Reset && (state_q == ST_RESP) && !ack_q && Req && we_q && !misaligned;

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_W)
    ) u_mem_array (
        .clk     (Clk),
        .we_i    (ram_we),
        .idx_i   (addr_q[ADDR_WIDTH-1:WORD_OFS_W]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    // Next-state and handshake logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    addr_d  = Addr;
                    we_d    = We;
                    wdata_d = WData;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!Req) begin
                    // Abort: no write, no Ack
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (!ack_q) begin
                    if (!Req) begin
                        state_d = ST_IDLE;
                    end else begin
                        ack_d = 1'b1;
                        if (misaligned) begin
                            err_d   = 1'b1;
                            rdata_d = '0;
                        end else begin
                            err_d   = 1'b0;
                            rdata_d = we_q ? wdata_q : ram_rdata;
                        end
                    end
                end else if (!Req) begin
                    // RData keeps its last value after the handshake closes
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered FSM state and outputs with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign RData = rdata_q;
    assign Ack   = ack_q;
    assign Err   = err_q;
    assign Busy  = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with 2 wait states, one with none,
// both checked against a word-array reference model and handshake timing rules.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req   [2];
    logic        we    [2];
    logic [9:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        err   [2];
    logic        busy  [2];

    int total = 0;
    int bad   = 0;

    // reference model: word contents and which words are known
    logic [31:0] mdl [2][256];
    bit          mv  [2][256];

    always #5 clk = ~clk;

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut_w2 (
        .Clk(clk), .Reset(rst_n), .Req(req[0]), .We(we[0]), .Addr(addr[0]),
        .WData(wdata[0]), .RData(rdata[0]), .Ack(ack[0]), .Err(err[0]), .Busy(busy[0])
    );

    mem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut_w0 (
        .Clk(clk), .Reset(rst_n), .Req(req[1]), .We(we[1]), .Addr(addr[1]),
        .WData(wdata[1]), .RData(rdata[1]), .Ack(ack[1]), .Err(err[1]), .Busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Ack is visible at the negedge after edge W+1, counting the accept edge as 0
    function automatic int lat_exp(input int s);
        return (s == 0) ? 4 : 2;
    endfunction

    // Full four-phase access; inputs scrambled after acceptance to prove latching
    task automatic access(input int s, input bit w, input logic [9:0] a,
                          input logic [31:0] d, input int hold);
        int          n;
        bit          mis;
        bit          known;
        logic [31:0] er;
        mis   = (a[1:0] != 2'b00);
        known = 1'b1;
        er    = '0;
        if (mis)                 er = '0;
        else if (w)              er = d;
        else if (mv[s][a[9:2]])  er = mdl[s][a[9:2]];
        else                     known = 1'b0;
        req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("busy_acc", {31'd0, busy[s]}, 32'd1);
                we[s] = 1'($urandom); addr[s] = 10'($urandom); wdata[s] = $urandom;
            end
        end while (!ack[s] && n < 40);
        chk("latency", n, lat_exp(s));
        chk("err", {31'd0, err[s]}, {31'd0, mis});
        if (known) chk("rdata", rdata[s], er);
        else er = rdata[s];
        if (!mis && w) begin
            mdl[s][a[9:2]] = d;
            mv[s][a[9:2]]  = 1'b1;
        end
        repeat (hold) begin
            @(negedge clk);
            chk("ack_hold", {31'd0, ack[s]}, 32'd1);
            chk("err_hold", {31'd0, err[s]}, {31'd0, mis});
            chk("rdata_hold", rdata[s], er);
        end
        req[s] = 1'b0;
        @(negedge clk);
        chk("ack_fall", {31'd0, ack[s]}, 32'd0);
        chk("err_fall", {31'd0, err[s]}, 32'd0);
        chk("busy_fall", {31'd0, busy[s]}, 32'd0);
        chk("rdata_keep", rdata[s], er);
    endtask

    // Write request dropped after k cycles in flight: must never Ack or write
    task automatic abort_wr(input int s, input logic [9:0] a, input logic [31:0] d, input int k);
        req[s] = 1'b1; we[s] = 1'b1; addr[s] = a; wdata[s] = d;
        repeat (k) begin
            @(negedge clk);
            chk("abort_noack", {31'd0, ack[s]}, 32'd0);
        end
        req[s] = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'd0, busy[s]}, 32'd0);
        chk("abort_ack", {31'd0, ack[s]}, 32'd0);
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
        end
        // reset: two edges low
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ack", {31'd0, ack[s]}, 32'd0);
            chk("rst_err", {31'd0, err[s]}, 32'd0);
            chk("rst_busy", {31'd0, busy[s]}, 32'd0);
            chk("rst_rdata", rdata[s], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // directed: write/read, misaligned, abort, held ack + gap
        access(0, 1'b1, 10'h010, 32'hDEADBEEF, 0);
        access(0, 1'b0, 10'h010, 32'h0, 0);
        access(0, 1'b1, 10'h013, 32'h12345678, 0);
        access(0, 1'b0, 10'h010, 32'h0, 0);
        access(0, 1'b1, 10'h020, 32'h0BADF00D, 0);
        abort_wr(0, 10'h020, 32'hA5A5A5A5, 1);
        access(0, 1'b0, 10'h020, 32'h0, 0);
        abort_wr(0, 10'h020, 32'hA5A5A5A5, 2);
        access(0, 1'b0, 10'h020, 32'h0, 5);
        access(0, 1'b0, 10'h010, 32'h0, 0);

        // reset mid-op on the zero-wait instance
        access(1, 1'b1, 10'h004, 32'h11112222, 0);
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 10'h004; wdata[1] = 32'h0000FFFF;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_ack", {31'd0, ack[1]}, 32'd0);
        chk("midrst_busy", {31'd0, busy[1]}, 32'd0);
        chk("midrst_rdata", rdata[1], 32'd0);
        req[1] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        access(1, 1'b0, 10'h004, 32'h0, 0);

        // randomized traffic on both instances
        for (int i = 0; i < 120; i++) begin
            int          s;
            logic [9:0]  a;
            s = int'($urandom_range(0, 1));
            a = 10'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if (s == 0 && $urandom_range(0, 6) == 0)
                abort_wr(0, a, $urandom, int'($urandom_range(1, 2)));
            else
                access(s, 1'($urandom), a, $urandom, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
